// File: rtl/mm_pkg.sv
// mm_pkg: shared encodings for the main-memory initiator.
// Op codes, widths, FSM states and the captured request bundle.
package mm_pkg;

   localparam int LINE_W = 256;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      OP_FILL = 2'd0,
      OP_WB   = 2'd1,
      OP_EVF  = 2'd2,
      OP_BYP  = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WB   = 3'd1,
      ST_RD   = 3'd2,
      ST_WAIT = 3'd3,
      ST_RESP = 3'd4
   } state_e;

   typedef struct packed {
      op_e               op;
      logic              wr;
      logic [31:0]       addr;
      logic [31:0]       wb_addr;
      logic [3:0]        be;
      logic [LINE_W-1:0] wdata;
   } req_t;

   function automatic logic [31:0] line_addr(
      input logic [31:0] a
   );
      return {a[31:5], 5'b0};
   endfunction

   function automatic logic [31:0] word_addr(
      input logic [31:0] a
   );
      return {a[31:2], 2'b0};
   endfunction

endpackage

// File: rtl/mm_timeout_ctr.sv
// mm_timeout_ctr: cycle counter for the read-wait window.
// done is raised in the last allowed wait cycle.
module mm_timeout_ctr #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic done
);

   localparam int W = $clog2(TIMEOUT + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset || clear)
         cnt <= '0;
      else if (en)
         cnt <= cnt + 1'b1;
   end

   assign done = en && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/mm_initiator.sv
// mm_initiator: cache-side request engine for banked main memory.
// One request in, one memory transaction sequence, one response out.
module mm_initiator
   import mm_pkg::*;
#(
   parameter int ADDR_BITS = 15,
   parameter int TIMEOUT   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic              req_wr,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wb_addr,
   input  logic [3:0]        req_be,
   input  logic [LINE_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [LINE_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic [31:0]       mm_a,
   output logic [3:0]        mm_be,
   output logic              mm_write,
   output logic              mm_read,
   output logic [LINE_W-1:0] mm_wd,
   output logic              mm_bypass,
   input  logic [LINE_W-1:0] mm_rd,
   input  logic              mm_valid
);

   localparam logic [31:0] HI_MASK =
      (ADDR_BITS >= 32) ? 32'h0 :
      ~((32'h1 << ADDR_BITS) - 32'h1);

   state_e            state;
   state_e            state_nx;
   req_t              req_q;
   logic              accept;
   logic              trap;
   logic              rd_first;
   logic              byp_rd;
   logic              tmo;
   logic              err_q;
   logic [LINE_W-1:0] data_q;

   assign req_ready = (state == ST_IDLE);
   assign accept    = req_valid && req_ready;
   assign rsp_valid = (state == ST_RESP);
   assign rsp_err   = rsp_valid && err_q;
   assign rsp_data  = rsp_valid ? data_q : '0;
   assign byp_rd    = (req_q.op == OP_BYP) && !req_q.wr;

   always_comb begin
      trap = |(req_addr & HI_MASK);
      if (op_e'(req_op) == OP_EVF)
         trap = trap || |(req_wb_addr & HI_MASK);
   end

   // Plain fills and bypass reads skip the write cycle
   always_comb begin
      rd_first = (op_e'(req_op) == OP_FILL) ||
                 ((op_e'(req_op) == OP_BYP) && !req_wr);
   end

   always_ff @(posedge clk) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               if (trap)
                  state_nx = ST_RESP;
               else if (rd_first)
                  state_nx = ST_RD;
               else
                  state_nx = ST_WB;
            end
         end
         ST_WB: begin
            if (req_q.op == OP_EVF)
               state_nx = ST_RD;
            else
               state_nx = ST_RESP;
         end
         ST_RD:
            state_nx = ST_WAIT;
         ST_WAIT: begin
            if (mm_valid || tmo)
               state_nx = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready)
               state_nx = ST_IDLE;
         end
         default:
            state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         req_q  <= '0;
         data_q <= '0;
         err_q  <= 1'b0;
      end else if (accept) begin
         req_q.op      <= op_e'(req_op);
         req_q.wr      <= req_wr;
         req_q.addr    <= req_addr;
         req_q.wb_addr <= req_wb_addr;
         req_q.be      <= req_be;
         req_q.wdata   <= req_wdata;
         data_q        <= '0;
         err_q         <= trap;
      end else if (state == ST_WAIT) begin
         // Data arriving on the timeout cycle still wins
         if (mm_valid) begin
            data_q <= byp_rd ?
               LINE_W'(mm_rd[WORD_W-1:0]) : mm_rd;
            err_q  <= 1'b0;
         end else if (tmo) begin
            err_q  <= 1'b1;
         end
      end
   end

   mm_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk   (clk),
      .reset (reset),
      .clear (state != ST_WAIT),
      .en    (state == ST_WAIT),
      .done  (tmo)
   );

   always_comb begin
      mm_a      = '0;
      mm_be     = '0;
      mm_write  = 1'b0;
      mm_read   = 1'b0;
      mm_wd     = '0;
      mm_bypass = 1'b0;
      unique case (state)
         ST_WB: begin
            mm_write = 1'b1;
            if (req_q.op == OP_BYP) begin
               mm_a      = word_addr(req_q.addr);
               mm_be     = req_q.be;
               mm_bypass = 1'b1;
               mm_wd     =
                  LINE_W'(req_q.wdata[WORD_W-1:0]);
            end else begin
               mm_a  = line_addr(
                  (req_q.op == OP_EVF) ?
                  req_q.wb_addr : req_q.addr);
               mm_be = 4'hF;
               mm_wd = req_q.wdata;
            end
         end
         ST_RD, ST_WAIT: begin
            mm_read   = (state == ST_RD);
            mm_bypass = byp_rd;
            mm_a      = byp_rd ?
               word_addr(req_q.addr) :
               line_addr(req_q.addr);
         end
         default: begin
         end
      endcase
   end

endmodule
